fifo_asym_sync: RTL

- Single-clock synchronous FIFO with asymmetric write and read widths. Ratio is a power of two and may run in either direction (wide-to-narrow or narrow-to-wide).
- Successor to the fixed 256-in/16-out asynchronous FIFO IP. Adds parametric width ratio, a lane-order option, flush, registered read-valid and sticky overflow/underflow flags.
- Sits between the DDR read-burst path and the pixel/stream datapaths of the video pipeline.

---
 rtl/fifo_asym_sync.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/fifo_asym_sync.sv
// -----------------------------------------------------------------------------
// fifo_asym_sync
//
// Single-clock FIFO whose write and read ports have different widths. The
// larger width is a power-of-two multiple of the smaller one, and the ratio
// can go either way. It sits between the DDR read-burst path and the
// pixel/stream datapaths.
//
// Storage is counted in units of U = min(W,R) bits. A write adds WK = W/U
// units and a read removes RK = R/U units. Physically the RAM is organised as
// rows of max(W,R) bits. The wide side always accesses a whole row. The narrow
// side accesses one lane of a row, and the lane index follows LSB_FIRST.
//
// Every flag and level is registered and recomputed from the next-cycle unit
// count. An access therefore becomes visible one cycle after it is accepted.
//
// Ports
//   clk              clock for all logic
//   rst_n            synchronous active-low reset
//   flush            synchronous clear of pointers and flags (rd_data kept)
//   wr_data/wr_en    write word and request
//   wr_full          no room for one more write word
//   wr_water_level   stored data in whole write words
//   almost_full      wr_water_level >= ALMOST_FULL_NUM
//   wr_overflow      sticky: a write was attempted while wr_full
//   rd_en            read request
//   rd_data          registered read word
//   rd_valid         rd_data was loaded by a read accepted at this edge
//   rd_empty         fewer than RK units stored
//   rd_water_level   stored data in whole read words
//   almost_empty     rd_water_level <= ALMOST_EMPTY_NUM
//   rd_underflow     sticky: a read was attempted while rd_empty
//
// Constraint: DEPTH_WIDTH must exceed log2(max(W,R)/min(W,R)), so that the
// RAM has at least two rows.
// -----------------------------------------------------------------------------
module fifo_asym_sync #(
  parameter  int WR_DATA_WIDTH    = 256,
  parameter  int RD_DATA_WIDTH    = 16,
  parameter  int DEPTH_WIDTH      = 14,
  parameter  int ALMOST_FULL_NUM  = 60,
  parameter  int ALMOST_EMPTY_NUM = 4,
  parameter  int LSB_FIRST        = 1,
  localparam int UNIT_W           = (WR_DATA_WIDTH < RD_DATA_WIDTH) ?
                                    WR_DATA_WIDTH : RD_DATA_WIDTH,
  localparam int WK               = WR_DATA_WIDTH / UNIT_W,
  localparam int RK               = RD_DATA_WIDTH / UNIT_W,
  localparam int WR_DEPTH_WIDTH   = DEPTH_WIDTH - $clog2(WK),
  localparam int RD_DEPTH_WIDTH   = DEPTH_WIDTH - $clog2(RK)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic                      wr_overflow,
  input  logic                      rd_en,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  output logic                      rd_valid,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty,
  output logic                      rd_underflow
);

  localparam int WLOG     = $clog2(WK);
  localparam int RLOG     = $clog2(RK);
  localparam int ROW_K    = (WK > RK) ? WK : RK;     // units per RAM row
  localparam int ROW_LOG  = $clog2(ROW_K);
  localparam int ROW_BITS = ROW_K * UNIT_W;
  localparam int ROW_AW   = DEPTH_WIDTH - ROW_LOG;
  localparam int ROWS     = 1 << ROW_AW;
  localparam int WPR      = ROW_K / WK;              // write words per row
  localparam int RPR      = ROW_K / RK;              // read words per row
  localparam int WSH      = ROW_LOG - WLOG;
  localparam int RSH      = ROW_LOG - RLOG;
  localparam int OFF_W    = (ROW_BITS > 1) ? $clog2(ROW_BITS) : 1;
  localparam int CNT_W    = DEPTH_WIDTH + 1;
  localparam int TOTAL    = 1 << DEPTH_WIDTH;
  localparam int WL_W     = WR_DEPTH_WIDTH + 1;
  localparam int RL_W     = RD_DEPTH_WIDTH + 1;

  // Map the n-th narrow access within a row onto its physical lane.
  // LSB_FIRST=0 walks the lanes from the top of the row downwards.
  function automatic int lane_of(input int slot, input int per_row);
    return (LSB_FIRST != 0) ? slot : (per_row - 1 - slot);
  endfunction

  // Flag thresholds, evaluated on the next-cycle unit count.
  function automatic logic is_full(input logic [CNT_W-1:0] units);
    return units > CNT_W'(TOTAL - WK);
  endfunction

  function automatic logic is_empty(input logic [CNT_W-1:0] units);
    return units < CNT_W'(RK);
  endfunction

  logic [ROW_BITS-1:0]       mem [ROWS];

  // Pointers count whole words on their own side and wrap naturally, because
  // both address spaces are powers of two that cover exactly TOTAL units.
  logic [WR_DEPTH_WIDTH-1:0] wr_ptr;
  logic [RD_DEPTH_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]          cnt;

  logic                      wr_acc_p0;
  logic                      rd_acc_p0;
  logic [CNT_W-1:0]          cnt_p0;
  logic                      full_p0;
  logic                      empty_p0;
  logic [WL_W-1:0]           wr_lvl_p0;
  logic [RL_W-1:0]           rd_lvl_p0;
  logic                      af_p0;
  logic                      ae_p0;

  logic [ROW_AW-1:0]         wr_row;
  logic [ROW_AW-1:0]         rd_row;
  logic [OFF_W-1:0]          wr_off;
  logic [OFF_W-1:0]          rd_off;

  // ---- stage p0: accept decisions and next-cycle occupancy ----
  // Acceptance uses only the registered flags. A simultaneous read and write
  // therefore never sees a partially updated count.
  assign wr_acc_p0 = rst_n && !flush && wr_en && !wr_full;
  assign rd_acc_p0 = rst_n && !flush && rd_en && !rd_empty;

  always_comb begin
    if (!rst_n || flush) begin
      cnt_p0 = '0;
    end else begin
      cnt_p0 = cnt + (wr_acc_p0 ? CNT_W'(WK) : CNT_W'(0))
                   - (rd_acc_p0 ? CNT_W'(RK) : CNT_W'(0));
    end
  end

  assign full_p0   = is_full(cnt_p0);
  assign empty_p0  = is_empty(cnt_p0);
  assign wr_lvl_p0 = WL_W'(cnt_p0 >> WLOG);
  assign rd_lvl_p0 = RL_W'(cnt_p0 >> RLOG);
  assign af_p0     = (int'(wr_lvl_p0) >= ALMOST_FULL_NUM);
  assign ae_p0     = (int'(rd_lvl_p0) <= ALMOST_EMPTY_NUM);

  // Row and lane for each side. The low pointer bits select the lane within
  // a row. On the wide side there is one word per row, so the lane is 0.
  always_comb begin
    wr_row = ROW_AW'(wr_ptr >> WSH);
    rd_row = ROW_AW'(rd_ptr >> RSH);
    wr_off = OFF_W'(lane_of(int'(wr_ptr) % WPR, WPR) * WR_DATA_WIDTH);
    rd_off = OFF_W'(lane_of(int'(rd_ptr) % RPR, RPR) * RD_DATA_WIDTH);
  end

  // ---- stage p1: registered storage, pointers, flags and read word ----
  // The RAM write port has no reset. The pointers alone define the contents.
  // An accepted write never targets a row that holds the unit being read in
  // the same cycle, so no read-during-write bypass is required.
  always_ff @(posedge clk) begin
    if (wr_acc_p0) begin
      mem[wr_row][wr_off +: WR_DATA_WIDTH] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else if (flush) begin
      // rd_data deliberately keeps its last value across a flush.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      if (wr_acc_p0) begin
        wr_ptr <= wr_ptr + WR_DEPTH_WIDTH'(1);
      end
      if (rd_acc_p0) begin
        rd_ptr  <= rd_ptr + RD_DEPTH_WIDTH'(1);
        rd_data <= mem[rd_row][rd_off +: RD_DATA_WIDTH];
      end
      if (wr_en && wr_full) begin
        wr_overflow <= 1'b1;
      end
      if (rd_en && rd_empty) begin
        rd_underflow <= 1'b1;
      end
      rd_valid <= rd_acc_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt            <= '0;
      wr_full        <= 1'b0;
      rd_empty       <= 1'b1;
      wr_water_level <= '0;
      rd_water_level <= '0;
      almost_full    <= (ALMOST_FULL_NUM <= 0);
      almost_empty   <= (ALMOST_EMPTY_NUM >= 0);
    end else begin
      // Under flush cnt_p0 is already zero, so flush needs no separate branch.
      cnt            <= cnt_p0;
      wr_full        <= full_p0;
      rd_empty       <= empty_p0;
      wr_water_level <= wr_lvl_p0;
      rd_water_level <= rd_lvl_p0;
      almost_full    <= af_p0;
      almost_empty   <= ae_p0;
    end
  end

endmodule
